fp_normalize_pack: RTL and testbench

- Encode side of the floating-point path: converts the unnormalized sign/exponent/wide-mantissa result of the adder datapath into a packed IEEE-754 single (`float_t`).
- It is the counterpart of the package's decode/classify functions.
- Multi-cycle block: 1-bit-per-cycle normalizing shifter, round-to-nearest-even, overflow/underflow handling.
- valid/ready handshake on both sides; sits between adder mantissa datapath and result register.

---
 rtl/fp_normalize_pack_pkg.sv | 27 ++
 rtl/fp_normalize_pack_round.sv | 58 +++++
 rtl/fp_normalize_pack.sv | 167 ++++++++++++++++
 tb/tb_fp_normalize_pack.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/fp_normalize_pack_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fp_normalize_pack_pkg
// Description : Shared float encoding types and constants for the FP path.
// Revision    : 1.0 - initial release
// ============================================================================
package fp_normalize_pack_pkg;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] frac;
    } float_t;

    localparam int          FP_BIAS      = 127;
    localparam logic [7:0]  FP_EXP_MAX   = 8'hFF;
    localparam logic [31:0] FP_CANON_NAN = 32'h7FC0_0000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_NORM  = 2'd1,
        ST_ROUND = 2'd2,
        ST_DONE  = 2'd3
    } fpnorm_state_t;

endpackage
`default_nettype wire

// File: rtl/fp_normalize_pack_round.sv
`default_nettype none
// ============================================================================
// Module      : fp_round_rne
// Description : Combinational round-to-nearest-even and IEEE flag generation.
// Revision    : 1.0 - initial release
// ============================================================================
module fp_round_rne
    import fp_normalize_pack_pkg::*;
#(
    parameter int MW = 28,
    parameter int XW = 11
) (
    input  logic                 i_sign,
    input  logic signed [XW-1:0] i_exp,
    input  logic [MW-1:0]        i_mant,
    output float_t               o_float,
    output logic                 o_overflow,
    output logic                 o_underflow,
    output logic                 o_inexact
);

    localparam int UW = MW - 3;
    localparam logic signed [XW-1:0] c_exp_one = XW'(1);
    localparam logic signed [XW-1:0] c_exp_inf = XW'(FP_EXP_MAX);

    logic                 w_inc;
    logic [UW-1:0]        w_upper;
    logic                 w_carry;
    logic                 w_hidden;
    logic [22:0]          w_frac;
    logic signed [XW-1:0] w_exp_r;

    always_comb begin
        w_inc    = i_mant[2] & (i_mant[1] | i_mant[0] | i_mant[3]);
        // Only bits [MW-1:3] take the increment; bit MW-1 is clear on entry so
        // the top bit of the sum is the round carry.
        w_upper  = i_mant[MW-1:3] + {{(UW-1){1'b0}}, w_inc};
        w_carry  = w_upper[UW-1];
        w_hidden = w_carry | w_upper[UW-2];
        w_frac   = w_carry ? w_upper[UW-2:1] : w_upper[UW-3:0];
        w_exp_r  = w_carry ? (i_exp + c_exp_one) : i_exp;

        o_inexact  = |i_mant[2:0];
        o_overflow = (w_exp_r >= c_exp_inf);

        o_float.sign = i_sign;
        if (o_overflow) begin
            o_float.exp  = FP_EXP_MAX;
            o_float.frac = '0;
        end else begin
            o_float.exp  = w_hidden ? w_exp_r[7:0] : 8'd0;
            o_float.frac = w_frac;
        end
        o_underflow = o_inexact & ~o_overflow & ~w_hidden;
    end

endmodule
`default_nettype wire

// File: rtl/fp_normalize_pack.sv
`default_nettype none
// ============================================================================
// Module      : fp_normalize_pack
// Description : Multi-cycle normalize / RNE round / pack to IEEE-754 single.
// Revision    : 1.0 - initial release
// ============================================================================
module fp_normalize_pack
    import fp_normalize_pack_pkg::*;
#(
    parameter int MW         = 28,
    parameter int EW         = 10,
    parameter int MAX_RSHIFT = 30
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_sign,
    input  logic [EW-1:0] in_exp,
    input  logic [MW-1:0] in_mant,
    input  logic          in_nan,
    input  logic          in_inf,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [31:0]   out_float,
    output logic          out_overflow,
    output logic          out_underflow,
    output logic          out_inexact
);

    localparam int XW = EW + 1;
    localparam int CW = $clog2(MAX_RSHIFT + 1);
    localparam logic signed [XW-1:0] c_exp_one = XW'(1);

    fpnorm_state_t        state_q, state_d;
    logic                 sign_q, sign_d;
    logic signed [XW-1:0] exp_q, exp_d;
    logic [MW-1:0]        mant_q, mant_d;
    logic [CW-1:0]        rcnt_q, rcnt_d;
    float_t               float_q, float_d;
    logic                 ovf_q, ovf_d;
    logic                 unf_q, unf_d;
    logic                 inx_q, inx_d;

    float_t               w_rnd_float;
    logic                 w_rnd_ovf;
    logic                 w_rnd_unf;
    logic                 w_rnd_inx;

    fp_round_rne #(
        .MW (MW),
        .XW (XW)
    ) u_round (
        .i_sign      (sign_q),
        .i_exp       (exp_q),
        .i_mant      (mant_q),
        .o_float     (w_rnd_float),
        .o_overflow  (w_rnd_ovf),
        .o_underflow (w_rnd_unf),
        .o_inexact   (w_rnd_inx)
    );

    always_comb begin
        state_d = state_q;
        sign_d  = sign_q;
        exp_d   = exp_q;
        mant_d  = mant_q;
        rcnt_d  = rcnt_q;
        float_d = float_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        inx_d   = inx_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    sign_d = in_sign;
                    exp_d  = {in_exp[EW-1], in_exp};
                    mant_d = in_mant;
                    rcnt_d = '0;
                    ovf_d  = 1'b0;
                    unf_d  = 1'b0;
                    inx_d  = 1'b0;
                    if (in_nan) begin
                        float_d = FP_CANON_NAN;
                        state_d = ST_DONE;
                    end else if (in_inf) begin
                        float_d = {in_sign, FP_EXP_MAX, 23'd0};
                        state_d = ST_DONE;
                    end else if (in_mant == '0) begin
                        float_d = {in_sign, 31'd0};
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_NORM;
                    end
                end
            end
            ST_NORM: begin
                if (mant_q[MW-1]) begin
                    mant_d = {1'b0, mant_q[MW-1:2], mant_q[1] | mant_q[0]};
                    exp_d  = exp_q + c_exp_one;
                end else if (exp_q < c_exp_one) begin
                    // Deep underflow: everything has become sticky, stop shifting.
                    if (rcnt_q == CW'(MAX_RSHIFT)) begin
                        mant_d = {{(MW-1){1'b0}}, |mant_q};
                        exp_d  = c_exp_one;
                    end else begin
                        mant_d = {1'b0, mant_q[MW-1:2], mant_q[1] | mant_q[0]};
                        exp_d  = exp_q + c_exp_one;
                        rcnt_d = rcnt_q + 1'b1;
                    end
                end else if (!mant_q[MW-2] && (exp_q > c_exp_one)) begin
                    mant_d = {mant_q[MW-2:0], 1'b0};
                    exp_d  = exp_q - c_exp_one;
                end else begin
                    state_d = ST_ROUND;
                end
            end
            ST_ROUND: begin
                float_d = w_rnd_float;
                ovf_d   = w_rnd_ovf;
                unf_d   = w_rnd_unf;
                inx_d   = w_rnd_inx;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            sign_q  <= 1'b0;
            exp_q   <= '0;
            mant_q  <= '0;
            rcnt_q  <= '0;
            float_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            inx_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sign_q  <= sign_d;
            exp_q   <= exp_d;
            mant_q  <= mant_d;
            rcnt_q  <= rcnt_d;
            float_q <= float_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            inx_q   <= inx_d;
        end
    end

    assign in_ready      = (state_q == ST_IDLE);
    assign out_valid     = (state_q == ST_DONE);
    assign out_float     = float_q;
    assign out_overflow  = ovf_q;
    assign out_underflow = unf_q;
    assign out_inexact   = inx_q;

endmodule
`default_nettype wire

// File: tb/tb_fp_normalize_pack.sv
`default_nettype none
// ============================================================================
// Module      : tb_fp_normalize_pack
// Description : Directed self-checking bench for fp_normalize_pack.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fp_normalize_pack;

    logic        clk;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [9:0]  in_exp;
    logic [27:0] in_mant;
    logic        in_nan;
    logic        in_inf;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_float;
    logic        out_overflow;
    logic        out_underflow;
    logic        out_inexact;

    int checks = 0;
    int errors = 0;

    fp_normalize_pack #(
        .MW         (28),
        .EW         (10),
        .MAX_RSHIFT (30)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_sign       (in_sign),
        .in_exp        (in_exp),
        .in_mant       (in_mant),
        .in_nan        (in_nan),
        .in_inf        (in_inf),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_float     (out_float),
        .out_overflow  (out_overflow),
        .out_underflow (out_underflow),
        .out_inexact   (out_inexact)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, expv);
        end
    endtask

    // Launch one item and wait (bounded) for its result; exp_lat < 0 skips latency.
    task automatic run_op(input string tag, input logic s, input logic [9:0] e,
                          input logic [27:0] m, input logic nan, input logic inf,
                          input logic [31:0] exp_f, input logic [2:0] exp_flags,
                          input int exp_lat);
        int cyc;
        cyc = 0;
        while (!in_ready && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
        end
        check({tag, "_rdy"}, {31'd0, in_ready}, 32'd1);
        in_sign  = s;
        in_exp   = e;
        in_mant  = m;
        in_nan   = nan;
        in_inf   = inf;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        cyc = 1;
        while (!out_valid && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        check({tag, "_vld"}, {31'd0, out_valid}, 32'd1);
        if (exp_lat >= 0) check({tag, "_lat"}, cyc, exp_lat);
        check({tag, "_flt"}, out_float, exp_f);
        check({tag, "_flg"}, {29'd0, out_overflow, out_underflow, out_inexact}, {29'd0, exp_flags});
    endtask

    task automatic accept(input string tag);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, "_acc_vld"}, {31'd0, out_valid}, 32'd0);
        check({tag, "_acc_rdy"}, {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_sign   = 1'b0;
        in_exp    = '0;
        in_mant   = '0;
        in_nan    = 1'b0;
        in_inf    = 1'b0;
        out_ready = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_rdy", {31'd0, in_ready}, 32'd1);
        check("rst_vld", {31'd0, out_valid}, 32'd0);
        check("rst_flt", out_float, 32'd0);
        check("rst_flg", {29'd0, out_overflow, out_underflow, out_inexact}, 32'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Normal path, shifts and RNE
        run_op("one",   1'b0, 10'd127, 28'h400_0000, 1'b0, 1'b0, 32'h3F80_0000, 3'b000, 3);
        accept("one");
        run_op("two",   1'b0, 10'd127, 28'h800_0000, 1'b0, 1'b0, 32'h4000_0000, 3'b000, 4);
        accept("two");
        run_op("lsh",   1'b0, 10'd127, 28'h000_0008, 1'b0, 1'b0, 32'h3400_0000, 3'b000, 26);
        accept("lsh");
        run_op("tie_e", 1'b0, 10'd127, 28'h400_0004, 1'b0, 1'b0, 32'h3F80_0000, 3'b001, 3);
        accept("tie_e");
        run_op("tie_o", 1'b0, 10'd127, 28'h400_000C, 1'b0, 1'b0, 32'h3F80_0002, 3'b001, 3);
        accept("tie_o");
        run_op("ovf",   1'b0, 10'd254, 28'h7FF_FFFC, 1'b0, 1'b0, 32'h7F80_0000, 3'b101, 3);
        accept("ovf");

        // Specials and zero
        run_op("nan",   1'b0, 10'd127, 28'h400_0000, 1'b1, 1'b1, 32'h7FC0_0000, 3'b000, 1);
        accept("nan");
        run_op("ninf",  1'b1, 10'd0,   28'h000_0000, 1'b0, 1'b1, 32'hFF80_0000, 3'b000, 1);
        accept("ninf");
        run_op("nzero", 1'b1, 10'd50,  28'h000_0000, 1'b0, 1'b0, 32'h8000_0000, 3'b000, 1);
        accept("nzero");

        // Underflow / denormals
        run_op("dnm",   1'b0, 10'h3FB, 28'h400_0000, 1'b0, 1'b0, 32'h0002_0000, 3'b000, 9);
        accept("dnm");
        run_op("dnm_s", 1'b0, 10'h3FB, 28'h400_0001, 1'b0, 1'b0, 32'h0002_0000, 3'b011, 9);
        accept("dnm_s");
        run_op("d2n",   1'b0, 10'd1,   28'h3FF_FFFC, 1'b0, 1'b0, 32'h0080_0000, 3'b001, 3);
        accept("d2n");
        run_op("clps",  1'b1, 10'h39C, 28'h400_0000, 1'b0, 1'b0, 32'h8000_0000, 3'b011, -1);
        accept("clps");

        // Output held stable under backpressure
        run_op("stall", 1'b1, 10'd127, 28'h400_0000, 1'b0, 1'b0, 32'hBF80_0000, 3'b000, 3);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("stall_vld", {31'd0, out_valid}, 32'd1);
            check("stall_flt", out_float, 32'hBF80_0000);
        end
        accept("stall");

        // Asynchronous reset in the middle of normalization
        in_sign  = 1'b0;
        in_exp   = 10'd127;
        in_mant  = 28'h000_0008;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("mid_busy", {31'd0, in_ready}, 32'd0);
        reset_n = 1'b0;
        #1;
        check("mid_rst_vld", {31'd0, out_valid}, 32'd0);
        check("mid_rst_rdy", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        run_op("post",  1'b0, 10'd128, 28'h600_0000, 1'b0, 1'b0, 32'h4040_0000, 3'b000, 3);
        accept("post");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
